exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- EXE pipeline stage. Sits directly downstream of the decode stage and upstream of the MEM stage.
- Registers the decode control/data bus and computes the ALU result or link address (pc+4).
- Issues data-memory read/write requests through an addr_ok handshake.
- Forwards results to MEM and exposes a forwarding bus back to decode.

Parameters:
- DS_TO_ES_BUS_WD, 279: decode-to-exe bus width (from shared header).
- ES_TO_MS_BUS_WD, 135: exe-to-mem bus width.
- ES_FWD_BUS_WD, 71: forwarding bus width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ms_allowin  in  1  MEM stage can accept
- es_allowin  out  1  EXE can accept
- ds_to_es_valid  in  1  decode output valid
- ds_to_es_bus  in  279  {alu_op[11:0], load_op, src2_is_imm, src2_is_rs2, jal_op, gr_we, mem_we, dest[4:0], imm[63:0], rs1_value[63:0], rs2_value[63:0], pc[63:0]} (MSB first)
- es_to_ms_valid  out  1  result valid to MEM
- es_to_ms_bus  out  135  {res_from_mem, gr_we, dest[4:0], result[63:0], pc[63:0]}
- es_fwd_bus  out  71  {fwd_we, fwd_dest[4:0], fwd_data[63:0]}
- data_sram_req  out  1  memory request
- data_sram_wr  out  1  1 = store, 0 = load
- data_sram_wstrb  out  8  byte enables
- data_sram_addr  out  64  byte address
- data_sram_wdata  out  64  store data
- data_sram_addr_ok  in  1  request accepted this cycle

Behaviour:
- Reset (clk, reset: synchronous, active-high). The following are cleared to 0:
  - es_valid, req_sent, and the bus register.
  - All outputs, with es_allowin = 1.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
  - When es_allowin: es_valid <= ds_to_es_valid.
  - When ds_to_es_valid && es_allowin: the bus register loads ds_to_es_bus.
  - Latency: 1 cycle for non-memory instructions.
- ALU operands:
  - src1 = rs1_value.
  - src2 = src2_is_imm ? imm : rs2_value.
- ALU result, selected by one-hot alu_op; all-zero alu_op gives 0:
  - [0] add: src1+src2, wraps mod 2^64.
  - [1] sub: src1-src2.
  - [2] slt: signed less-than → {63'b0, lt}.
  - [3] sltu: unsigned less-than → {63'b0, lt}.
  - [4] and, [5] nor, [6] or, [7] xor.
  - [8] sll, [9] srl, [10] sra: shift amount = src2[5:0].
  - [11] lui: result = src2.
- Final result = jal_op ? pc+4 : alu_result. jal_op overrides alu_op.
- Memory access:
  - mem_acc = load_op || mem_we.
  - data_sram_req = es_valid && mem_acc && !req_sent.
  - data_sram_wr = mem_we.
  - data_sram_wstrb = mem_we ? 8'hFF : 8'h00.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rs2_value.
- es_ready_go = !mem_acc || req_sent || (data_sram_req && data_sram_addr_ok).
- req_sent register:
  - Set when the req && addr_ok handshake occurs and the instruction does not leave in that cycle (ms_allowin = 0).
  - Cleared when the instruction leaves (es_to_ms_valid && ms_allowin), or on reset.
  - Each memory instruction issues exactly one accepted request, regardless of MEM backpressure.
- Request state machine, encoded by req_sent:
  - IDLE → WAIT (req high, addr_ok low) → SENT (accepted, stalled) → IDLE on leave.
  - Accept plus leave in the same cycle goes straight back to IDLE.
- es_to_ms_bus: res_from_mem = load_op, plus gr_we, dest, final result, pc.
- es_fwd_bus:
  - fwd_we = es_valid && gr_we && dest != 0.
  - fwd_dest = dest.
  - fwd_data = final result. Not valid for loads: decode must stall on es_valid && load_op.
- Back-to-back instructions: accepted with no bubble while ms_allowin = 1.
- Simultaneous leave and enter: the new bus replaces the old in the same edge.
- Reset mid-request: the in-flight request is dropped and req_sent is cleared. The memory side sees req fall.

Decomposition:
- Shared header: add ES_TO_MS_BUS_WD, ES_FWD_BUS_WD, and named alu_op bit indices (ALU_ADD..ALU_LUI).
- One sub-module, alu: purely combinational, ports alu_op[11:0], src1[63:0], src2[63:0], result[63:0].
- exe_stage owns all sequential logic.

Test Plan:
- add, rs1 = 5, rs2 = 7, ms_allowin = 1 → next cycle es_to_ms_valid = 1, result = 12, data_sram_req = 0.
- sra src2_is_rs2, rs1 = 64'h8000_0000_0000_0000, rs2 = 4 → result = 64'hF800_0000_0000_0000. sltu 1 vs 64'hFFFF_FFFF_FFFF_FFFF → result = 1.
- jal, pc = 64'h8000_0010, alu_op[0] set → result = 64'h8000_0014, dest passed unchanged.
- sd, rs1 = 0x1000, imm = 8, rs2 = 0xAB, addr_ok held low for 3 cycles:
  - req held 3 cycles, addr = 0x1008, wstrb = FF, es_allowin = 0.
  - On addr_ok: es_to_ms_valid = 1.
- ld accepted (addr_ok = 1) while ms_allowin = 0 for 2 cycles → data_sram_req drops after one accept, no second request, leaves when ms_allowin = 1, res_from_mem = 1.
- reset asserted during WAIT → next cycle es_valid = 0, data_sram_req = 0, es_allowin = 1.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared bus widths, decode bus layout and one-hot ALU op indices
package exe_stage_pkg;
  localparam int DS_TO_ES_BUS_WD = 279;
  localparam int ES_TO_MS_BUS_WD = 135;
  localparam int ES_FWD_BUS_WD   = 71;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;
  typedef struct packed {
    logic [11:0] alu_op;
    logic        load_op;
    logic        src2_is_imm;
    logic        src2_is_rs2;
    logic        jal_op;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [63:0] imm;
    logic [63:0] rs1_value;
    logic [63:0] rs2_value;
    logic [63:0] pc;
  } ds_bus_t;
endpackage

// File: rtl/exe_stage_alu.sv
// exe_stage_alu: combinational 64-bit ALU driven by a one-hot op vector
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  output logic [63:0] result
);
  logic [5:0] sh;
  assign sh = src2[5:0];
  assign result = ({64{alu_op[ALU_ADD]}}  & (src1 + src2))
                | ({64{alu_op[ALU_SUB]}}  & (src1 - src2))
                | ({64{alu_op[ALU_SLT]}}  & {63'b0, $signed(src1) < $signed(src2)})
                | ({64{alu_op[ALU_SLTU]}} & {63'b0, src1 < src2})
                | ({64{alu_op[ALU_AND]}}  & (src1 & src2))
                | ({64{alu_op[ALU_NOR]}}  & ~(src1 | src2))
                | ({64{alu_op[ALU_OR]}}   & (src1 | src2))
                | ({64{alu_op[ALU_XOR]}}  & (src1 ^ src2))
                | ({64{alu_op[ALU_SLL]}}  & (src1 << sh))
                | ({64{alu_op[ALU_SRL]}}  & (src1 >> sh))
                | ({64{alu_op[ALU_SRA]}}  & 64'($signed(src1) >>> sh))
                | ({64{alu_op[ALU_LUI]}}  & src2);
endmodule

// File: rtl/exe_stage.sv
// exe_stage: EXE pipeline stage; registers the decode bus, computes ALU/link result,
// issues one accepted data-memory request per memory instruction, feeds MEM and decode forwarding
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  output logic                       data_sram_req,
  output logic                       data_sram_wr,
  output logic [7:0]                 data_sram_wstrb,
  output logic [63:0]                data_sram_addr,
  output logic [63:0]                data_sram_wdata,
  input  logic                       data_sram_addr_ok
);
  ds_bus_t     bus_q, bus_d;
  logic        es_valid_q, es_valid_d;
  logic        req_sent_q, req_sent_d;
  logic [63:0] src2, alu_result, final_result;
  logic        mem_acc, es_ready_go, leave, fwd_we;
  logic        unused_src2_is_rs2;
  assign unused_src2_is_rs2 = bus_q.src2_is_rs2;
  assign src2 = bus_q.src2_is_imm ? bus_q.imm : bus_q.rs2_value;
  exe_stage_alu u_alu (
    .alu_op (bus_q.alu_op),
    .src1   (bus_q.rs1_value),
    .src2   (src2),
    .result (alu_result)
  );
  assign final_result    = bus_q.jal_op ? bus_q.pc + 64'd4 : alu_result;
  assign mem_acc         = bus_q.load_op | bus_q.mem_we;
  assign data_sram_req   = es_valid_q & mem_acc & ~req_sent_q;
  assign data_sram_wr    = bus_q.mem_we;
  assign data_sram_wstrb = {8{bus_q.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = bus_q.rs2_value;
  assign es_ready_go     = ~mem_acc | req_sent_q | (data_sram_req & data_sram_addr_ok);
  assign es_allowin      = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid  = es_valid_q & es_ready_go;
  assign leave           = es_to_ms_valid & ms_allowin;
  assign fwd_we          = es_valid_q & bus_q.gr_we & (bus_q.dest != 5'd0);
  assign es_to_ms_bus    = {bus_q.load_op, bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};
  // top bit of the forwarding bus is a zero pad to the shared 71-bit width
  assign es_fwd_bus      = {1'b0, fwd_we, bus_q.dest, final_result};
  always_comb begin
    es_valid_d = es_allowin ? ds_to_es_valid : es_valid_q;
    bus_d      = (ds_to_es_valid && es_allowin) ? ds_bus_t'(ds_to_es_bus) : bus_q;
    req_sent_d = leave ? 1'b0 : (data_sram_req && data_sram_addr_ok) ? 1'b1 : req_sent_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      req_sent_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      req_sent_q <= req_sent_d;
      bus_q      <= bus_d;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized and directed checks of exe_stage against a behavioural model
module tb_exe_stage;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ms_allowin = 1'b1;
  logic         es_allowin;
  logic         ds_to_es_valid = 1'b0;
  logic [278:0] ds_to_es_bus = '0;
  logic         es_to_ms_valid;
  logic [134:0] es_to_ms_bus;
  logic [70:0]  es_fwd_bus;
  logic         data_sram_req, data_sram_wr;
  logic [7:0]   data_sram_wstrb;
  logic [63:0]  data_sram_addr, data_sram_wdata;
  logic         data_sram_addr_ok = 1'b0;
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  exe_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus), .es_fwd_bus(es_fwd_bus),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (!reset && data_sram_req && data_sram_addr_ok) acc_cnt <= acc_cnt + 1;

  function automatic logic [278:0] mk(logic [11:0] op, logic ld, logic imm_sel, logic jal,
                                      logic gr_we, logic we, logic [4:0] dest, logic [63:0] imm,
                                      logic [63:0] rs1, logic [63:0] rs2, logic [63:0] pc);
    return {op, ld, imm_sel, ~imm_sel, jal, gr_we, we, dest, imm, rs1, rs2, pc};
  endfunction

  // operation k of 0..11 in ALU order, anything else yields 0
  function automatic logic [63:0] ref_op(int k, logic [63:0] a, logic [63:0] b);
    longint sa = a;
    longint sb = b;
    int n = int'(b % 64);
    case (k)
      0: return a + b;
      1: return a - b;
      2: return (sa < sb) ? 64'd1 : 64'd0;
      3: return (a < b) ? 64'd1 : 64'd0;
      4: return a & b;
      5: return ~(a | b);
      6: return a | b;
      7: return a ^ b;
      8: return a << n;
      9: return a >> n;
      10: return 64'(sa >>> n);
      11: return b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic send(input logic [278:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = b;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (es_allowin !== 1'b1 || es_to_ms_valid !== 1'b0 || data_sram_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got allowin=%b valid=%b req=%b exp 1 0 0", es_allowin, es_to_ms_valid, data_sram_req);
    end
    checks++;
    if (es_to_ms_bus !== '0 || es_fwd_bus !== '0 || data_sram_addr !== '0 || data_sram_wdata !== '0 ||
        data_sram_wstrb !== '0 || data_sram_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got ms_bus=%h fwd=%h addr=%h exp all zero", es_to_ms_bus, es_fwd_bus, data_sram_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add;
    ms_allowin = 1'b1;
    send(mk(12'h001, 0, 0, 0, 1, 0, 5'd3, 64'd0, 64'd5, 64'd7, 64'h100));
    @(negedge clk);
    checks++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[127:64] !== 64'd12 || data_sram_req !== 1'b0) begin
      errors++;
      $display("FAIL add got valid=%b res=%h req=%b exp 1 12 0", es_to_ms_valid, es_to_ms_bus[127:64], data_sram_req);
    end
    checks++;
    if (es_fwd_bus !== {1'b0, 1'b1, 5'd3, 64'd12}) begin
      errors++;
      $display("FAIL add_fwd got %h exp %h", es_fwd_bus, {1'b0, 1'b1, 5'd3, 64'd12});
    end
  endtask

  task automatic test_alu_directed;
    send(mk(12'h400, 0, 0, 0, 1, 0, 5'd1, 64'd0, 64'h8000_0000_0000_0000, 64'd4, 64'h0));
    @(negedge clk);
    checks++;
    if (es_to_ms_bus[127:64] !== 64'hF800_0000_0000_0000) begin
      errors++;
      $display("FAIL sra got %h exp f800000000000000", es_to_ms_bus[127:64]);
    end
    @(posedge clk); #1;
    send(mk(12'h008, 0, 0, 0, 1, 0, 5'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0));
    @(negedge clk);
    checks++;
    if (es_to_ms_bus[127:64] !== 64'd1) begin
      errors++;
      $display("FAIL sltu got %h exp 1", es_to_ms_bus[127:64]);
    end
    @(posedge clk); #1;
    send(mk(12'h000, 0, 0, 0, 1, 0, 5'd1, 64'd0, 64'd9, 64'd9, 64'h0));
    @(negedge clk);
    checks++;
    if (es_to_ms_bus[127:64] !== 64'd0) begin
      errors++;
      $display("FAIL no_op got %h exp 0", es_to_ms_bus[127:64]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_random;
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 12);
      logic [11:0] op = (k < 12) ? 12'(1 << k) : 12'h000;
      logic imm_sel = 1'($urandom);
      logic gr_we = 1'($urandom);
      logic [4:0] dest = (i == 0) ? 5'd0 : 5'($urandom);
      logic [63:0] rs1 = {32'($urandom), 32'($urandom)};
      logic [63:0] rs2 = (i % 3 == 0) ? 64'($urandom_range(0, 70)) : {32'($urandom), 32'($urandom)};
      logic [63:0] imm = {32'($urandom), 32'($urandom)};
      logic [63:0] pc = {32'($urandom), 32'($urandom)};
      logic [63:0] exp = ref_op(k, rs1, imm_sel ? imm : rs2);
      send(mk(op, 0, imm_sel, 0, gr_we, 0, dest, imm, rs1, rs2, pc));
      @(negedge clk);
      checks++;
      if (es_to_ms_valid !== 1'b1 || es_to_ms_bus !== {1'b0, gr_we, dest, exp, pc}) begin
        errors++;
        $display("FAIL alu_rand op=%0d got valid=%b bus=%h exp bus=%h", k, es_to_ms_valid, es_to_ms_bus, {1'b0, gr_we, dest, exp, pc});
      end
      checks++;
      if (es_fwd_bus !== {1'b0, gr_we && dest != 0, dest, exp}) begin
        errors++;
        $display("FAIL fwd_rand op=%0d got %h exp %h", k, es_fwd_bus, {1'b0, gr_we && dest != 0, dest, exp});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jal;
    send(mk(12'h001, 0, 1, 1, 1, 0, 5'd7, 64'd100, 64'd3, 64'd4, 64'h8000_0010));
    @(negedge clk);
    checks++;
    if (es_to_ms_bus !== {1'b0, 1'b1, 5'd7, 64'h8000_0014, 64'h8000_0010}) begin
      errors++;
      $display("FAIL jal got %h exp %h", es_to_ms_bus, {1'b0, 1'b1, 5'd7, 64'h8000_0014, 64'h8000_0010});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b;
    ms_allowin = 1'b1;
    a = 64'($urandom);
    b = 64'($urandom);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(12'h001, 0, 0, 0, 1, 0, 5'd1, 64'd0, a, b, 64'd0);
    for (int i = 0; i < 8; i++) begin
      logic [63:0] exp = a + b + 64'(i == 0 ? 0 : 0);
      @(posedge clk); #1;
      a = 64'($urandom);
      b = 64'($urandom);
      ds_to_es_bus = mk(12'h001, 0, 0, 0, 1, 0, 5'(i + 2), 64'd0, a, b, 64'(i + 1));
      @(negedge clk);
      checks++;
      if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b1 || es_to_ms_bus[127:64] !== exp ||
          es_to_ms_bus[63:0] !== 64'(i)) begin
        errors++;
        $display("FAIL b2b[%0d] got valid=%b allowin=%b res=%h pc=%h exp res=%h pc=%0d", i,
                 es_to_ms_valid, es_allowin, es_to_ms_bus[127:64], es_to_ms_bus[63:0], exp, i);
      end
    end
    ds_to_es_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (es_to_ms_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got valid=%b exp 0", es_to_ms_valid);
    end
  endtask

  task automatic test_store_wait;
    int base;
    ms_allowin = 1'b1;
    data_sram_addr_ok = 1'b0;
    base = acc_cnt;
    send(mk(12'h001, 0, 1, 0, 0, 1, 5'd0, 64'd8, 64'h1000, 64'hAB, 64'h200));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (data_sram_req !== 1'b1 || data_sram_wr !== 1'b1 || data_sram_addr !== 64'h1008 ||
          data_sram_wstrb !== 8'hFF || data_sram_wdata !== 64'hAB || es_allowin !== 1'b0 ||
          es_to_ms_valid !== 1'b0) begin
        errors++;
        $display("FAIL sd_wait[%0d] got req=%b wr=%b addr=%h strb=%h wdata=%h allowin=%b valid=%b", c,
                 data_sram_req, data_sram_wr, data_sram_addr, data_sram_wstrb, data_sram_wdata, es_allowin, es_to_ms_valid);
      end
      @(posedge clk); #1;
    end
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (es_to_ms_valid !== 1'b1 || es_allowin !== 1'b1 || data_sram_req !== 1'b1) begin
      errors++;
      $display("FAIL sd_accept got valid=%b allowin=%b req=%b exp 1 1 1", es_to_ms_valid, es_allowin, data_sram_req);
    end
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (es_to_ms_valid !== 1'b0 || data_sram_req !== 1'b0 || acc_cnt - base !== 1) begin
      errors++;
      $display("FAIL sd_done got valid=%b req=%b accepts=%0d exp 0 0 1", es_to_ms_valid, data_sram_req, acc_cnt - base);
    end
  endtask

  task automatic test_load_backpressure;
    int base;
    @(posedge clk); #1;
    ms_allowin = 1'b0;
    data_sram_addr_ok = 1'b1;
    base = acc_cnt;
    send(mk(12'h001, 1, 1, 0, 1, 0, 5'd5, 64'd16, 64'h2000, 64'h55, 64'h300));
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b1 || data_sram_wr !== 1'b0 || data_sram_wstrb !== 8'h00 ||
        data_sram_addr !== 64'h2010 || es_allowin !== 1'b0) begin
      errors++;
      $display("FAIL ld_first got req=%b wr=%b strb=%h addr=%h allowin=%b", data_sram_req, data_sram_wr,
               data_sram_wstrb, data_sram_addr, es_allowin);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b0 || es_to_ms_valid !== 1'b1 || es_allowin !== 1'b0) begin
      errors++;
      $display("FAIL ld_stall got req=%b valid=%b allowin=%b exp 0 1 0", data_sram_req, es_to_ms_valid, es_allowin);
    end
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b0 || es_to_ms_valid !== 1'b1 || es_to_ms_bus[134] !== 1'b1 ||
        es_to_ms_bus[127:64] !== 64'h2010 || es_allowin !== 1'b1) begin
      errors++;
      $display("FAIL ld_leave got req=%b valid=%b rfm=%b res=%h allowin=%b exp 0 1 1 2010 1", data_sram_req,
               es_to_ms_valid, es_to_ms_bus[134], es_to_ms_bus[127:64], es_allowin);
    end
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (acc_cnt - base !== 1 || es_to_ms_valid !== 1'b0) begin
      errors++;
      $display("FAIL ld_accepts got accepts=%0d valid=%b exp 1 0", acc_cnt - base, es_to_ms_valid);
    end
  endtask

  task automatic test_reset_mid_request;
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    data_sram_addr_ok = 1'b0;
    send(mk(12'h001, 1, 1, 0, 1, 0, 5'd9, 64'd0, 64'h3000, 64'd0, 64'h400));
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got req=%b exp 1", data_sram_req);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (es_to_ms_valid !== 1'b0 || data_sram_req !== 1'b0 || es_allowin !== 1'b1 || es_fwd_bus !== '0) begin
      errors++;
      $display("FAIL rst_mid got valid=%b req=%b allowin=%b fwd=%h exp 0 0 1 0", es_to_ms_valid,
               data_sram_req, es_allowin, es_fwd_bus);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    @(posedge clk); #1;
    test_alu_directed();
    test_alu_random();
    test_jal();
    test_back_to_back();
    @(posedge clk); #1;
    test_store_wait();
    test_load_backpressure();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
